// File: rtl/regfile_onehot_wr.sv
`default_nettype none
// ============================================================================
// Module   : regfile_onehot_wr
// Summary  : 32-entry register file with a one-hot write port, two registered
//            read ports, write-to-read bypass and malformed-select detection.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_onehot_wr #(
   parameter int DATA_WIDTH = 32,
   parameter bit ZERO_REG   = 1'b1
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_wr_en,
   input  logic [31:0]           i_wr_sel,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic [4:0]            i_rd_addr_a,
   input  logic [4:0]            i_rd_addr_b,
   output logic [DATA_WIDTH-1:0] o_rd_data_a,
   output logic [DATA_WIDTH-1:0] o_rd_data_b,
   output logic                  o_sel_err
);

   localparam int c_NUM_REGS = 32;

   logic                  w_sel_onehot;
   logic                  w_wr_valid;
   logic                  w_wr_bad;
   logic [DATA_WIDTH-1:0] w_regs [c_NUM_REGS];
   logic                  w_hit_a;
   logic                  w_hit_b;
   logic                  w_zero_a;
   logic                  w_zero_b;
   logic [DATA_WIDTH-1:0] w_next_a;
   logic [DATA_WIDTH-1:0] w_next_b;
   logic [DATA_WIDTH-1:0] r_rd_data_a;
   logic [DATA_WIDTH-1:0] r_rd_data_b;
   logic                  r_sel_err;

   // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
   assign w_sel_onehot = (i_wr_sel != 32'd0) && ((i_wr_sel & (i_wr_sel - 32'd1)) == 32'd0);
   assign w_wr_valid   = i_wr_en & w_sel_onehot;
   assign w_wr_bad     = i_wr_en & ~w_sel_onehot;

   generate
      for (genvar k = 0; k < c_NUM_REGS; k++) begin : g_entry
         if (ZERO_REG && (k == 0)) begin : g_zero
            assign w_regs[k] = '0;
         end else begin : g_reg
            logic [DATA_WIDTH-1:0] r_q;
            always_ff @(posedge i_clk or negedge i_rst_n) begin
               if (!i_rst_n) begin
                  r_q <= '0;
               end else if (w_wr_valid && i_wr_sel[k]) begin
                  r_q <= i_wr_data;
               end
            end
            assign w_regs[k] = r_q;
         end
      end
   endgenerate

   // A one-hot select bit at the read address is a same-cycle hit.
   assign w_hit_a  = w_wr_valid & i_wr_sel[i_rd_addr_a];
   assign w_hit_b  = w_wr_valid & i_wr_sel[i_rd_addr_b];
   assign w_zero_a = ZERO_REG && (i_rd_addr_a == 5'd0);
   assign w_zero_b = ZERO_REG && (i_rd_addr_b == 5'd0);

   always_comb begin
      w_next_a = w_regs[i_rd_addr_a];
      w_next_b = w_regs[i_rd_addr_b];
      if (w_hit_a) w_next_a = i_wr_data;
      if (w_hit_b) w_next_b = i_wr_data;
      if (w_zero_a) w_next_a = '0;
      if (w_zero_b) w_next_b = '0;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rd_data_a <= '0;
         r_rd_data_b <= '0;
         r_sel_err   <= 1'b0;
      end else begin
         r_rd_data_a <= w_next_a;
         r_rd_data_b <= w_next_b;
         r_sel_err   <= w_wr_bad;
      end
   end

   assign o_rd_data_a = r_rd_data_a;
   assign o_rd_data_b = r_rd_data_b;
   assign o_sel_err   = r_sel_err;

endmodule
`default_nettype wire

// File: tb/tb_regfile_onehot_wr.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_onehot_wr
// Summary  : Directed and randomized checks of regfile_onehot_wr, both with and
//            without the hardwired zero register, against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_onehot_wr;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en;
   logic [31:0] wr_sel;
   logic [31:0] wr_data;
   logic [4:0]  ra;
   logic [4:0]  rb;
   logic [31:0] a1, b1, a0, b0;
   logic        e1, e0;

   int n_vec = 0;
   int n_err = 0;

   // Reference contents: m1 for the ZERO_REG=1 instance, m0 for ZERO_REG=0.
   logic [31:0] m1 [32];
   logic [31:0] m0 [32];

   always #5 clk = ~clk;

   regfile_onehot_wr #(.DATA_WIDTH(32), .ZERO_REG(1'b1)) dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_sel(wr_sel),
      .i_wr_data(wr_data), .i_rd_addr_a(ra), .i_rd_addr_b(rb),
      .o_rd_data_a(a1), .o_rd_data_b(b1), .o_sel_err(e1)
   );

   regfile_onehot_wr #(.DATA_WIDTH(32), .ZERO_REG(1'b0)) dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_sel(wr_sel),
      .i_wr_data(wr_data), .i_rd_addr_a(ra), .i_rd_addr_b(rb),
      .o_rd_data_a(a0), .o_rd_data_b(b0), .o_sel_err(e0)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < 32; i++) begin
         m1[i] = 32'd0;
         m0[i] = 32'd0;
      end
   endtask

   // One clock cycle: apply a write and two reads, then check all outputs.
   task automatic step(input logic en, input logic [31:0] sel, input logic [31:0] data,
                       input logic [4:0] addr_a, input logic [4:0] addr_b, input string tag);
      int          idx;
      bit          valid;
      bit          bad;
      logic [31:0] xa1, xb1, xa0, xb0;
      @(negedge clk);
      wr_en = en; wr_sel = sel; wr_data = data; ra = addr_a; rb = addr_b;
      idx = -1;
      for (int i = 0; i < 32; i++) if (sel[i]) idx = i;
      valid = en && ($countones(sel) == 1);
      bad   = en && ($countones(sel) != 1);
      xa0 = (valid && idx == int'(addr_a)) ? data : m0[addr_a];
      xb0 = (valid && idx == int'(addr_b)) ? data : m0[addr_b];
      xa1 = (addr_a == 5'd0) ? 32'd0 : xa0 == m0[addr_a] && !(valid && idx == int'(addr_a)) ? m1[addr_a] : data;
      xb1 = (addr_b == 5'd0) ? 32'd0 : xb0 == m0[addr_b] && !(valid && idx == int'(addr_b)) ? m1[addr_b] : data;
      if (valid) begin
         m0[idx] = data;
         if (idx != 0) m1[idx] = data;
      end
      @(posedge clk);
      #1;
      chk({tag, ".a_z1"}, a1, xa1);
      chk({tag, ".b_z1"}, b1, xb1);
      chk({tag, ".err_z1"}, {31'd0, e1}, {31'd0, bad});
      chk({tag, ".a_z0"}, a0, xa0);
      chk({tag, ".b_z0"}, b0, xb0);
      chk({tag, ".err_z0"}, {31'd0, e0}, {31'd0, bad});
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".a_z1"}, a1, 32'd0);
      chk({tag, ".b_z1"}, b1, 32'd0);
      chk({tag, ".err_z1"}, {31'd0, e1}, 32'd0);
      chk({tag, ".a_z0"}, a0, 32'd0);
      chk({tag, ".b_z0"}, b0, 32'd0);
      chk({tag, ".err_z0"}, {31'd0, e0}, 32'd0);
   endtask

   initial begin
      logic [31:0] sel;
      logic [4:0]  r;
      rst_n = 1'b0; wr_en = 1'b0; wr_sel = '0; wr_data = '0; ra = '0; rb = '0;
      clear_model();
      repeat (3) @(posedge clk);
      #1 chk_zero("reset_hold");
      @(negedge clk); rst_n = 1'b1;

      // Mid-run asynchronous reset, following a write and an error pulse.
      step(1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 5'd5, 5'd31, "wr_r5");
      step(1'b1, 32'h0000_0030, 32'h0BAD_0BAD, 5'd5, 5'd5, "bad_before_rst");
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1 chk_zero("async_rst");
      clear_model();
      @(negedge clk); rst_n = 1'b1;
      step(1'b0, 32'd0, 32'd0, 5'd5, 5'd31, "read_after_rst");

      // Basic write then read.
      step(1'b1, 32'h0000_0008, 32'h1234_5678, 5'd0, 5'd1, "wr_r3");
      step(1'b0, 32'd0, 32'd0, 5'd3, 5'd3, "rd_r3");

      // Bypass on both ports.
      step(1'b1, 32'h0000_0080, 32'h1111_1111, 5'd0, 5'd0, "wr_r7_old");
      step(1'b1, 32'h0000_0080, 32'hA5A5_A5A5, 5'd7, 5'd7, "bypass_r7");
      chk("bypass_r7_abs", a1, 32'hA5A5_A5A5);

      // Malformed selects.
      step(1'b1, 32'h0000_0002, 32'h0000_0001, 5'd0, 5'd0, "wr_r1");
      step(1'b1, 32'h0000_0004, 32'h0000_0002, 5'd0, 5'd0, "wr_r2");
      step(1'b1, 32'h0000_0006, 32'hFFFF_FFFF, 5'd1, 5'd2, "bad_two_bits");
      chk("bad_err_abs", {31'd0, e1}, 32'd1);
      step(1'b0, 32'd0, 32'd0, 5'd1, 5'd2, "after_bad");
      chk("keep_r1_abs", a1, 32'h0000_0001);
      chk("keep_r2_abs", b1, 32'h0000_0002);
      step(1'b1, 32'd0, 32'hFFFF_FFFF, 5'd1, 5'd2, "bad_zero_sel");
      step(1'b0, 32'd0, 32'd0, 5'd1, 5'd2, "after_bad_zero");
      step(1'b0, 32'h0000_0006, 32'hFFFF_FFFF, 5'd1, 5'd2, "en_low_sel6");

      // Register 0 with and without the hardwiring.
      step(1'b1, 32'h0000_0001, 32'hCAFE_F00D, 5'd0, 5'd0, "wr_r0_bypass");
      chk("r0_z0_bypass_abs", a0, 32'hCAFE_F00D);
      step(1'b0, 32'd0, 32'd0, 5'd0, 5'd0, "rd_r0");

      // Sweep with bypass on B and prior value on A.
      for (int k = 1; k < 32; k++) begin
         sel = 32'd1 << k;
         step(1'b1, sel, k * 32'h0101_0101, 5'(k - 1), 5'(k), "sweep");
      end
      for (int k = 0; k < 32; k += 2)
         step(1'b0, 32'd0, 32'd0, 5'(k), 5'(k + 1), "readback");

      // Randomized traffic mixing valid, empty and multi-bit selects.
      for (int n = 0; n < 300; n++) begin
         r = 5'($urandom_range(0, 31));
         case ($urandom_range(0, 5))
            0:       sel = 32'd0;
            1:       sel = $urandom;
            default: sel = 32'd1 << r;
         endcase
         step(1'($urandom_range(0, 3) != 0), sel, $urandom,
              5'($urandom_range(0, 31)), ($urandom_range(0, 2) == 0) ? r : 5'($urandom_range(0, 31)),
              "random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
